keccak_absorb_buffer: RTL

- Parametrised input front-end for keccak_unbuffered.
- Accepts a narrow word stream with a last flag and applies Keccak pad10*1 padding at byte granularity.
- Assembles rate-wide blocks and hands them to the core over a valid/ready handshake, one block at a time.
- Replaces hand-padded, full-width din stimulus and supports multi-block and zero-length messages.

---
 rtl/keccak_absorb_buffer.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/keccak_absorb_buffer.sv
// Narrow-word front-end for keccak_unbuffered: packs words into rate-wide blocks with pad10*1.
// Optional KECCAK_ABSORB_MSGLEN_EN adds a running message byte count output (msg_len).
module keccak_absorb_buffer #(
   parameter int WORD_W = 64,
   parameter int RATE_W = 1024
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic [WORD_W-1:0]           in_data,
   input  logic                        in_valid,
   input  logic                        in_last,
   input  logic [$clog2(WORD_W/8):0]   in_bytes,
   output logic                        in_ready,
   output logic [RATE_W-1:0]           blk_data,
   output logic                        blk_valid,
   output logic                        blk_last,
   input  logic                        blk_ready
`ifdef KECCAK_ABSORB_MSGLEN_EN
   ,
   output logic [31:0]                 msg_len
`endif
);

   localparam int N   = RATE_W / WORD_W;
   localparam int WB  = WORD_W / 8;
   localparam int RB  = RATE_W / 8;
   localparam int BYW = $clog2(WB) + 1;
   localparam int IW  = (N > 1) ? $clog2(N) : 1;
   localparam int PW  = $clog2(RB + 1);

   localparam logic [0:0] S_FILL = 1'b0;
   localparam logic [0:0] S_HOLD = 1'b1;

   logic [0:0]        state_q, state_d;
   logic [IW-1:0]     idx_q, idx_d;
   logic              pad_pending_q, pad_pending_d;
   logic [RATE_W-1:0] buf_q, buf_d;
   logic              blk_last_q, blk_last_d;
   logic              blk_valid_q, blk_valid_d;

   logic              word_acc_s;
   logic              blk_xfer_s;
   logic [BYW-1:0]    nbytes_s;
   logic [PW-1:0]     pos_s;
   logic [WORD_W-1:0] wr_word_s;

   assign in_ready   = (state_q == S_FILL) && !reset;
   assign word_acc_s = in_valid && in_ready;
   assign blk_xfer_s = blk_valid_q && blk_ready;
   assign nbytes_s   = (in_bytes > BYW'(WB)) ? BYW'(WB) : in_bytes;
   // Byte position of the first pad byte, in the range 0..RB.
   assign pos_s      = PW'(idx_q) * PW'(WB) + PW'(nbytes_s);

   assign blk_data  = buf_q;
   assign blk_valid = blk_valid_q;
   assign blk_last  = blk_last_q;

   // Incoming word with bytes beyond the valid count cleared on the final word.
   always_comb begin
      wr_word_s = '0;
      for (int j = 0; j < WB; j++) begin
         if (!in_last || (BYW'(j) < nbytes_s)) begin
            wr_word_s[j*8 +: 8] = in_data[j*8 +: 8];
         end else begin
            wr_word_s[j*8 +: 8] = 8'h00;
         end
      end
   end

   // Fill/hold sequencing and block assembly.
   always_comb begin
      state_d       = state_q;
      idx_d         = idx_q;
      pad_pending_d = pad_pending_q;
      buf_d         = buf_q;
      blk_last_d    = blk_last_q;
      blk_valid_d   = blk_valid_q;
      case (state_q)
         S_FILL: begin
            if (word_acc_s) begin
               buf_d[idx_q*WORD_W +: WORD_W] = wr_word_s;
               if (in_last) begin
                  // Words above idx are already zero because the buffer is cleared per block.
                  if (pos_s < PW'(RB)) begin
                     buf_d[pos_s*8 +: 8]     = buf_d[pos_s*8 +: 8] | 8'h01;
                     buf_d[RATE_W-8 +: 8]    = buf_d[RATE_W-8 +: 8] | 8'h80;
                     blk_last_d              = 1'b1;
                  end else begin
                     pad_pending_d = 1'b1;
                     blk_last_d    = 1'b0;
                  end
                  state_d     = S_HOLD;
                  blk_valid_d = 1'b1;
               end else if (idx_q == IW'(N - 1)) begin
                  state_d     = S_HOLD;
                  blk_valid_d = 1'b1;
                  blk_last_d  = 1'b0;
               end else begin
                  idx_d = idx_q + IW'(1);
               end
            end else begin
               blk_valid_d = 1'b0;
            end
         end
         S_HOLD: begin
            if (blk_xfer_s) begin
               buf_d = '0;
               if (pad_pending_q) begin
                  buf_d[7:0]          = 8'h01;
                  buf_d[RATE_W-1 -: 8] = 8'h80;
                  blk_last_d          = 1'b1;
                  pad_pending_d       = 1'b0;
               end else begin
                  idx_d       = '0;
                  blk_last_d  = 1'b0;
                  blk_valid_d = 1'b0;
                  state_d     = S_FILL;
               end
            end else begin
               blk_valid_d = 1'b1;
            end
         end
         default: begin
            state_d       = S_FILL;
            idx_d         = '0;
            pad_pending_d = 1'b0;
            buf_d         = '0;
            blk_last_d    = 1'b0;
            blk_valid_d   = 1'b0;
         end
      endcase
   end

   // State and block registers.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q       <= S_FILL;
         idx_q         <= '0;
         pad_pending_q <= 1'b0;
         buf_q         <= '0;
         blk_last_q    <= 1'b0;
         blk_valid_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         idx_q         <= idx_d;
         pad_pending_q <= pad_pending_d;
         buf_q         <= buf_d;
         blk_last_q    <= blk_last_d;
         blk_valid_q   <= blk_valid_d;
      end
   end

`ifdef KECCAK_ABSORB_MSGLEN_EN
   logic [31:0] msg_len_q, msg_len_d;
   logic        msg_start_q, msg_start_d;

   assign msg_len = msg_len_q;

   // Byte count restarts at the first word after a final word.
   always_comb begin
      msg_len_d   = msg_len_q;
      msg_start_d = msg_start_q;
      if (word_acc_s) begin
         msg_len_d   = (msg_start_q ? 32'd0 : msg_len_q) +
                       (in_last ? 32'(nbytes_s) : 32'(WB));
         msg_start_d = in_last;
      end else begin
         msg_start_d = msg_start_q;
      end
   end

   // Message length registers.
   always_ff @(posedge clock) begin
      if (reset) begin
         msg_len_q   <= 32'd0;
         msg_start_q <= 1'b1;
      end else begin
         msg_len_q   <= msg_len_d;
         msg_start_q <= msg_start_d;
      end
   end
`endif

endmodule
